// File: rtl/core_pkg.sv
// Shared definitions for the RV32 core front end: fetch FSM states and the
// canonical NOP (addi x0,x0,0) used to reset pipeline registers.
package core_pkg;
  localparam int          XLEN_DEF = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_DROP
  } fetch_state_e;
endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register. Priority: flush > load > stall-hold > drain.
import core_pkg::*;

module ifid_reg #(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_flush,
  input  logic            i_load,
  input  logic            i_stall,
  input  logic [XLEN-1:0] i_pc,
  input  logic [31:0]     i_inst,
  output logic            o_valid,
  output logic [XLEN-1:0] o_pc,
  output logic [31:0]     o_inst
);
  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_inst;

  // A load overrides stall: the caller only loads when the slot is free or drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_inst  <= NOP_INST;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_inst  <= i_inst;
    end else if (!i_stall) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_inst  = r_inst;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding imem requester, one-entry hold
// buffer for decode stalls, and redirect flush handling.
import core_pkg::*;

module fetch_stage #(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_rvalid,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            ifid_valid,
  output logic [XLEN-1:0] ifid_pc,
  output logic [XLEN-1:0] ifid_pc4,
  output logic [31:0]     ifid_inst
);
  fetch_state_e    r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt, w_pc4, w_redir_pc;
  logic [XLEN-1:0] r_hold_pc;
  logic [31:0]     r_hold_inst;
  logic            w_req, w_load, w_hold_cap;
  logic [XLEN-1:0] w_addr, w_load_pc;
  logic [31:0]     w_load_inst;
  logic [1:0]      w_unused_redir;

  assign w_pc4          = r_pc + XLEN'(4);
  assign w_redir_pc     = {redirect_pc[XLEN-1:2], 2'b00};
  assign w_unused_redir = redirect_pc[1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_req       = 1'b0;
    w_addr      = r_pc;
    w_load      = 1'b0;
    w_load_pc   = r_pc;
    w_load_inst = imem_rdata;
    w_hold_cap  = 1'b0;
    unique case (r_state)
      ST_REQ: begin
        if (redirect_valid) begin
          w_pc_nxt = w_redir_pc;
        end else begin
          w_req       = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = imem_rvalid ? ST_REQ : ST_DROP;
        end else if (imem_rvalid) begin
          w_pc_nxt = w_pc4;
          // Back-to-back: next request leaves in the same cycle the response lands.
          if (!ifid_valid || !stall) begin
            w_load = 1'b1;
            w_req  = 1'b1;
            w_addr = w_pc4;
          end else begin
            w_hold_cap  = 1'b1;
            w_state_nxt = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = ST_REQ;
        end else if (!stall) begin
          w_load      = 1'b1;
          w_load_pc   = r_hold_pc;
          w_load_inst = r_hold_inst;
          w_state_nxt = ST_REQ;
        end
      end
      ST_DROP: begin
        if (redirect_valid) w_pc_nxt = w_redir_pc;
        if (imem_rvalid)    w_state_nxt = ST_REQ;
      end
      default: w_state_nxt = ST_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_REQ;
      r_pc        <= {RESET_PC[XLEN-1:2], 2'b00};
      r_hold_pc   <= '0;
      r_hold_inst <= NOP_INST;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_hold_cap) begin
        r_hold_pc   <= r_pc;
        r_hold_inst <= imem_rdata;
      end
    end
  end

  assign imem_req  = w_req && !rst;
  assign imem_addr = w_addr;

  ifid_reg #(.XLEN(XLEN)) u_ifid (
    .clk     (clk),
    .rst     (rst),
    .i_flush (redirect_valid),
    .i_load  (w_load),
    .i_stall (stall),
    .i_pc    (w_load_pc),
    .i_inst  (w_load_inst),
    .o_valid (ifid_valid),
    .o_pc    (ifid_pc),
    .o_inst  (ifid_inst)
  );

  assign ifid_pc4 = ifid_pc + XLEN'(4);
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: two instances (RESET_PC 0 and 0xFFFF_FFFC),
// each with a single-outstanding memory model of configurable latency.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall, redir_v;
  logic [31:0] redir_pc;
  int          lat0;
  int          checks = 0;
  int          failures = 0;

  logic        req    [2];
  logic [31:0] addr   [2];
  logic [31:0] rdata  [2];
  logic        rvalid [2];
  logic        ivld   [2];
  logic [31:0] ipc    [2];
  logic [31:0] ipc4   [2];
  logic [31:0] iinst  [2];

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic        pend;
    logic [31:0] maddr;
    int          cnt;
    int          lat;
    int          viol = 0;

    assign lat      = (g == 0) ? lat0 : 1;
    assign rvalid[g] = pend && (cnt == 0);
    assign rdata[g]  = inst_of(maddr);

    always @(posedge clk) begin
      if (rst) begin
        pend <= 1'b0;
        cnt  <= 0;
      end else begin
        if (rvalid[g])  pend <= 1'b0;
        else if (pend)  cnt  <= cnt - 1;
        if (req[g]) begin
          if (pend && !rvalid[g]) viol <= viol + 1;
          pend  <= 1'b1;
          maddr <= addr[g];
          cnt   <= lat - 1;
        end
      end
    end

    fetch_stage #(
      .XLEN     (32),
      .RESET_PC ((g == 0) ? 32'h0000_0000 : 32'hFFFF_FFFC)
    ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (req[g]),
      .imem_addr      (addr[g]),
      .imem_rdata     (rdata[g]),
      .imem_rvalid    (rvalid[g]),
      .redirect_valid ((g == 0) ? redir_v : 1'b0),
      .redirect_pc    ((g == 0) ? redir_pc : 32'h0),
      .stall          ((g == 0) ? stall : 1'b0),
      .ifid_valid     (ivld[g]),
      .ifid_pc        (ipc[g]),
      .ifid_pc4       (ipc4[g]),
      .ifid_inst      (iinst[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redir_v = 1'b0; redir_pc = '0; lat0 = 1;
    nxt(); nxt(); mid();
    chk("rst_req",   req[0],   0);
    chk("rst_vld",   ivld[0],  0);
    chk("rst_inst",  iinst[0], 32'h13);
    chk("rst_pc",    ipc[0],   0);
    chk("rst_pc4",   ipc4[0],  4);
    chk("rst_req1",  req[1],   0);

    // 1-cycle memory, free-running
    nxt(); rst = 1'b0; mid();
    chk("c0_req",   req[0],  1);
    chk("c0_addr",  addr[0], 0);
    chk("c0_addr1", addr[1], 32'hFFFF_FFFC);
    nxt(); mid();
    chk("c1_req",   req[0],  1);
    chk("c1_addr",  addr[0], 4);
    chk("c1_vld",   ivld[0], 0);
    chk("c1_addr1", addr[1], 0);
    nxt(); mid();
    chk("c2_vld",   ivld[0],  1);
    chk("c2_pc",    ipc[0],   0);
    chk("c2_inst",  iinst[0], inst_of(32'h0));
    chk("c2_addr",  addr[0],  8);
    chk("c2_pc1",   ipc[1],   32'hFFFF_FFFC);
    chk("c2_pc41",  ipc4[1],  0);
    chk("c2_inst1", iinst[1], inst_of(32'hFFFF_FFFC));

    // stall while response for 8 arrives -> hold buffer
    nxt(); stall = 1'b1; mid();
    chk("c3_pc",  ipc[0], 4);
    chk("c3_req", req[0], 0);
    nxt(); mid();
    chk("c4_req", req[0],  0);
    chk("c4_vld", ivld[0], 1);
    chk("c4_pc",  ipc[0],  4);
    nxt(); stall = 1'b0; mid();
    chk("c5_req", req[0], 0);
    nxt(); mid();
    chk("c6_pc",   ipc[0],   8);
    chk("c6_inst", iinst[0], inst_of(32'h8));
    chk("c6_req",  req[0],   1);
    chk("c6_addr", addr[0],  12);
    nxt(); mid();
    chk("c7_vld",  ivld[0], 0);
    chk("c7_addr", addr[0], 16);

    // 3-cycle memory, redirect while waiting
    rst = 1'b1; lat0 = 3;
    nxt(); nxt(); rst = 1'b0; mid();
    chk("r0_addr", addr[0], 0);
    repeat (6) nxt();
    mid();
    chk("r6_req",  req[0],  1);
    chk("r6_addr", addr[0], 8);
    nxt(); redir_v = 1'b1; redir_pc = 32'h0000_0102; mid();
    chk("r7_req", req[0], 0);
    chk("r7_pc",  ipc[0], 4);
    nxt(); redir_v = 1'b0; mid();
    chk("r8_vld", ivld[0], 0);
    chk("r8_req", req[0],  0);
    nxt(); mid();
    chk("r9_rv",  rvalid[0], 1);
    chk("r9_req", req[0],    0);
    chk("r9_vld", ivld[0],   0);
    nxt(); mid();
    chk("r10_vld",  ivld[0], 0);
    chk("r10_req",  req[0],  1);
    chk("r10_addr", addr[0], 32'h100);
    nxt(); nxt(); nxt(); mid();
    chk("r13_addr", addr[0], 32'h104);
    nxt(); stall = 1'b1; mid();
    chk("r14_vld",  ivld[0],  1);
    chk("r14_pc",   ipc[0],   32'h100);
    chk("r14_inst", iinst[0], inst_of(32'h100));
    nxt(); mid();

    // redirect coincident with response under stall
    nxt(); redir_v = 1'b1; redir_pc = 32'h0000_0200; mid();
    chk("r16_rv",  rvalid[0], 1);
    chk("r16_req", req[0],    0);
    chk("r16_vld", ivld[0],   1);
    nxt(); redir_v = 1'b0; mid();
    chk("r17_vld",  ivld[0], 0);
    chk("r17_req",  req[0],  1);
    chk("r17_addr", addr[0], 32'h200);
    stall = 1'b0;
    nxt(); mid();

    chk("overlap0", g_dut[0].viol, 0);
    chk("overlap1", g_dut[1].viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
